frame_buffer: RTL

FRAME_BUFFER -- requirements
Module: frame_buffer

---
 rtl/frame_buffer_pkg.sv | 33 +++
 rtl/frame_buffer_if.sv | 10 +
 rtl/fb_half_ram.sv | 39 +++
 rtl/frame_buffer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/frame_buffer_pkg.sv
// Shared definitions for the double-buffered 64x64 RGB332 frame buffer.
package frame_buffer_pkg;

  localparam int FB_W      = 64;
  localparam int FB_H      = 64;
  localparam int FB_PIXELS = FB_W * FB_H;
  localparam int PIX_AW    = $clog2(FB_PIXELS);

  localparam int RGB_R_MSB = 7;
  localparam int RGB_R_LSB = 5;
  localparam int RGB_G_MSB = 4;
  localparam int RGB_G_LSB = 2;
  localparam int RGB_B_MSB = 1;
  localparam int RGB_B_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_FILL = 3'b010,
    S_PEND = 3'b100
  } wr_state_e;

  // Bit replication keeps full-scale codes at full scale: 0xFF maps to 0xFFFFFF.
  function automatic logic [23:0] rgb332_to_rgb24(input logic [7:0] p);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = p[RGB_R_MSB:RGB_R_LSB];
    g = p[RGB_G_MSB:RGB_G_LSB];
    b = p[RGB_B_MSB:RGB_B_LSB];
    return {{b, b, b, b}, {g, g, g[2:1]}, {r, r, r[2:1]}};
  endfunction

endpackage

// File: rtl/frame_buffer_if.sv
// Pixel write stream into the frame buffer.
interface frame_buffer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_sof;
  logic [7:0] wr_data;

  modport master (output wr_valid, output wr_sof, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_sof, input wr_data, output wr_ready);
endinterface

// File: rtl/fb_half_ram.sv
// One screen half (32 rows) of both buffers: simple dual-port RAM, registered read.
module fb_half_ram
  import frame_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic [PIX_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [PIX_AW-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [FB_PIXELS];
  logic [7:0] rdata_q;
  logic [7:0] rdata_d;

  always_comb begin
    rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered 64x64 RGB332 frame store: raster writes into the back buffer,
// swap to the front on a display frame boundary once a full frame is written.
//
// state  | meaning
// S_IDLE | waiting for a start-of-frame beat, others dropped
// S_FILL | writing pixels 1..4095 of the back buffer
// S_PEND | back buffer complete, stalled until next frame boundary
module frame_buffer
  import frame_buffer_pkg::*;
#(
  parameter int FRAME_BITS = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic [4:0]            addr,
  input  logic [5:0]            x,
  output logic [23:0]           rgb24_0,
  output logic [23:0]           rgb24_1,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_sof,
  input  logic [7:0]            wr_data,
  output logic                  swapped,
  output logic                  sync_err
);

  wr_state_e             state_q, state_d;
  logic [PIX_AW-1:0]     cnt_q, cnt_d;
  logic                  front_q, front_d;
  logic [FRAME_BITS-1:0] frame_q;
  logic                  wr_ready_q, wr_ready_d;
  logic                  swapped_q, swapped_d;
  logic                  sync_err_q, sync_err_d;

  logic              accept;
  logic              boundary;
  logic              we;
  logic [PIX_AW-1:0] wpix;
  logic [PIX_AW-1:0] waddr;
  logic [PIX_AW-1:0] raddr;
  logic [7:0]        rd_top;
  logic [7:0]        rd_bot;

  assign accept   = wr_valid & wr_ready_q;
  assign boundary = (frame != frame_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    front_d    = front_q;
    swapped_d  = 1'b0;
    sync_err_d = 1'b0;
    we         = 1'b0;
    wpix       = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && wr_sof) begin
          we      = 1'b1;
          wpix    = '0;
          cnt_d   = PIX_AW'(1);
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (accept) begin
          we = 1'b1;
          if (wr_sof) begin
            sync_err_d = 1'b1;
            wpix       = '0;
            cnt_d      = PIX_AW'(1);
          end else if (cnt_q == PIX_AW'(FB_PIXELS - 1)) begin
            cnt_d   = '0;
            state_d = S_PEND;
          end else begin
            cnt_d = cnt_q + PIX_AW'(1);
          end
        end
      end
      // A boundary seen while still in S_FILL is ignored, so a boundary that
      // coincides with the last pixel defers the swap to the next one.
      S_PEND: begin
        if (boundary) begin
          front_d   = ~front_q;
          swapped_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    wr_ready_d = (state_d != S_PEND);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      front_q    <= 1'b0;
      frame_q    <= frame;
      wr_ready_q <= 1'b0;
      swapped_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      front_q    <= front_d;
      frame_q    <= frame;
      wr_ready_q <= wr_ready_d;
      swapped_q  <= swapped_d;
      sync_err_q <= sync_err_d;
    end
  end

  // Row bit 5 picks the half; within a half the buffer bit keeps front and back apart.
  assign waddr = {~front_q, wpix[PIX_AW-2:0]};
  assign raddr = {front_q, addr, x};

  fb_half_ram u_ram_top (
    .clk    (clk),
    .resetn (resetn),
    .we     (we & resetn & ~wpix[PIX_AW-1]),
    .waddr  (waddr),
    .wdata  (wr_data),
    .raddr  (raddr),
    .rdata  (rd_top)
  );

  fb_half_ram u_ram_bot (
    .clk    (clk),
    .resetn (resetn),
    .we     (we & resetn & wpix[PIX_AW-1]),
    .waddr  (waddr),
    .wdata  (wr_data),
    .raddr  (raddr),
    .rdata  (rd_bot)
  );

  assign rgb24_0  = rgb332_to_rgb24(rd_top);
  assign rgb24_1  = rgb332_to_rgb24(rd_bot);
  assign wr_ready = wr_ready_q;
  assign swapped  = swapped_q;
  assign sync_err = sync_err_q;

endmodule
